// File: rtl/demux_tdm.sv
// Time-division demultiplexer: steers samples from a shared line into four
// channel registers, aligned by a frame-sync marker, with a frame strobe and sticky error.
module demux_tdm #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   d,
  input  logic           v,
  input  logic           sync,
  input  logic           clr,
  output logic [4*W-1:0] y,
  output logic [1:0]     s,
  output logic           locked,
  output logic           frame_valid,
  output logic           err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          s_q, s_d;
  logic [3:0][W-1:0]   y_q, y_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  logic                err_set;

  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    state_d = state_q;
    s_d     = s_q;
    y_d     = y_q;
    fv_d    = 1'b0;
    err_set = 1'b0;

    if (v) begin
      if (sync) begin
        // A sync always restarts the frame at slot 0; mid-frame it is a realignment.
        y_d[0]  = d;
        s_d     = 2'd1;
        state_d = LOCKED;
        err_set = (state_q == LOCKED) && (s_q != 2'd0);
      end else if (state_q == LOCKED) begin
        y_d[s_q] = d;
        s_d      = s_q + 2'd1;
        fv_d     = (s_q == 2'd3);
      end
    end

    // Set has priority over a same-cycle clear.
    err_d = err_set | (err_q & ~clr);
  end

  // The channel registers are few and must read zero after reset, so they are reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      s_q     <= 2'd0;
      y_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      s_q     <= s_d;
      y_q     <= y_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign y           = y_q;
  assign s           = s_q;
  assign locked      = (state_q == LOCKED);
  assign frame_valid = fv_q;
  assign err         = err_q;

endmodule
